// File: rtl/cgra_clock_gate_ctrl.sv
// cgra_clock_gate_ctrl: idle-detecting enable generator for the CGRA cluster clock gate
module cgra_clock_gate_ctrl #(
    parameter int IDLE_CNT_W  = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int STAT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_gating_i,
    input  logic [IDLE_CNT_W-1:0] idle_threshold_i,
    input  logic                  busy_i,
    input  logic                  wake_req_i,
    input  logic                  test_en_i,
    input  logic                  cnt_clr_i,
    output logic                  clk_en_o,
    output logic                  gated_o,
    output logic                  ready_o,
    output logic [STAT_W-1:0]     gate_cnt_o
);
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] GATED = 2'd1;
    localparam logic [1:0] WAKE  = 2'd2;
    localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES);

    logic [1:0]            state;
    logic [IDLE_CNT_W-1:0] idle_cnt;
    logic [3:0]            wake_cnt;
    logic                  idle;
    logic                  gate_now;

    // any non-idle input doubles as the wake condition while gated
    assign idle     = enable_gating_i & ~busy_i & ~wake_req_i & ~test_en_i;
    assign gate_now = (state == RUN) & idle & (idle_cnt >= idle_threshold_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= RUN;
            idle_cnt <= '0;
            wake_cnt <= '0;
            clk_en_o <= 1'b1;
            ready_o  <= 1'b1;
            gated_o  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (gate_now) begin
                        state    <= GATED;
                        idle_cnt <= '0;
                        clk_en_o <= 1'b0;
                        ready_o  <= 1'b0;
                        gated_o  <= 1'b1;
                    end else begin
                        idle_cnt <= idle ? idle_cnt + IDLE_CNT_W'(1) : '0;
                    end
                end
                GATED: begin
                    if (!idle) begin
                        state    <= WAKE;
                        wake_cnt <= 4'd1;
                        clk_en_o <= 1'b1;
                        gated_o  <= 1'b0;
                    end
                end
                WAKE: begin
                    if (wake_cnt >= WAKE_LAST) begin
                        state    <= RUN;
                        wake_cnt <= '0;
                        ready_o  <= 1'b1;
                    end else begin
                        wake_cnt <= wake_cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= RUN;
                    idle_cnt <= '0;
                    wake_cnt <= '0;
                    clk_en_o <= 1'b1;
                    ready_o  <= 1'b1;
                    gated_o  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || cnt_clr_i)
            gate_cnt_o <= '0;
        else if (gate_now && gate_cnt_o != '1)
            gate_cnt_o <= gate_cnt_o + STAT_W'(1);
    end
endmodule
